// File: rtl/risc4_pkg.sv
`default_nettype none
// ============================================================================
// risc4_pkg : opcodes, sequencer states and instruction field positions
// Rev 1.0
// ============================================================================
package risc4_pkg;

    // Codes 000-100 double as the ALU select values.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_JNZ = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 7;
    localparam int RS_MSB  = 6;
    localparam int RS_LSB  = 5;
    localparam int RSV_BIT = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/risc4_regfile.sv
`default_nettype none
// ============================================================================
// risc4_regfile : 4x4-bit register file, two operand reads, one debug read
// Rev 1.0
// ============================================================================
module risc4_regfile #(
    parameter  int NREG = 4,
    parameter  int DW   = 4,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o,
    input  logic [AW-1:0] dbg_sel_i,
    output logic [DW-1:0] dbg_data_o
);

    logic [DW-1:0] w_regs [NREG];

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        logic [DW-1:0] val_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_q <= '0;
            end else if (we_i && (waddr_i == AW'(g))) begin
                val_q <= wdata_i;
            end
        end

        assign w_regs[g] = val_q;
    end

    assign rdata_a_o  = w_regs[raddr_a_i];
    assign rdata_b_o  = w_regs[raddr_b_i];
    assign dbg_data_o = w_regs[dbg_sel_i];

endmodule
`default_nettype wire

// File: rtl/risc4_control_unit.sv
`default_nettype none
// ============================================================================
// risc4_control_unit : fetch/decode/execute sequencer owning pc, ir and regs
// Rev 1.0
// ============================================================================
module risc4_control_unit
    import risc4_pkg::*;
#(
    parameter int IW   = 12,
    parameter int PCW  = 4,
    parameter int NREG = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [PCW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_data,
    output logic [3:0]     alu_a,
    output logic [3:0]     alu_b,
    output logic [2:0]     alu_sel,
    input  logic [3:0]     alu_out,
    output logic [PCW-1:0] pc,
    output logic           halted,
    output logic           instr_done,
    input  logic [1:0]     dbg_sel,
    output logic [3:0]     dbg_data
);

    state_t         state_q;
    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_d;
    logic [IW-1:0]  ir_q;
    logic           halted_q;
    logic           done_q;

    logic [2:0]     w_op;
    logic [1:0]     w_rd;
    logic [1:0]     w_rs;
    logic [3:0]     w_imm;
    logic           w_we;
    logic [3:0]     w_wdata;
    logic           unused_rsv;

    assign w_op       = ir_q[OP_MSB:OP_LSB];
    assign w_rd       = ir_q[RD_MSB:RD_LSB];
    assign w_rs       = ir_q[RS_MSB:RS_LSB];
    assign w_imm      = ir_q[IMM_MSB:IMM_LSB];
    assign unused_rsv = ir_q[RSV_BIT];

    // Single write port, active only while executing a writing opcode.
    assign w_we    = (state_q == S_EXECUTE) && (w_op != OP_JNZ) && (w_op != OP_HLT);
    assign w_wdata = (w_op == OP_LDI) ? w_imm : alu_out;

    risc4_regfile #(
        .NREG (NREG),
        .DW   (4)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (w_we),
        .waddr_i    (w_rd),
        .wdata_i    (w_wdata),
        .raddr_a_i  (w_rd),
        .rdata_a_o  (alu_a),
        .raddr_b_i  (w_rs),
        .rdata_b_o  (alu_b),
        .dbg_sel_i  (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    always_comb begin
        pc_d = pc_q + PCW'(1);
        if (w_op == OP_HLT) begin
            pc_d = pc_q;
        end else if ((w_op == OP_JNZ) && (alu_a != 4'd0)) begin
            pc_d = PCW'(w_imm);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q    <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    ir_q    <= imem_data;
                    done_q  <= 1'b1;
                    state_q <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    pc_q <= pc_d;
                    if (w_op == OP_HLT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q  <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc_q     <= '0;
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign alu_sel    = w_op;
    assign halted     = halted_q;
    assign instr_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_risc4_control_unit.sv
`default_nettype none
// tb_risc4_control_unit : program vectors, corner sequences and random programs
// checked against an instruction-level model of the 4-bit RISC core.
module tb_risc4_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  imem_addr;
    logic [11:0] imem_data;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_out;
    logic [3:0]  pc;
    logic        halted;
    logic        instr_done;
    logic [1:0]  dbg_sel = 2'd0;
    logic [3:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    risc4_control_unit #(.IW(12), .PCW(4), .NREG(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .pc         (pc),
        .halted     (halted),
        .instr_done (instr_done),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory and combinational ALU environment.
    logic [11:0] imem [16];
    always @(posedge clk) imem_data <= imem[imem_addr];

    always_comb begin
        case (alu_sel)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = ~alu_a;
            default: alu_out = 4'd0;
        endcase
    end

    always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] enc(input int op, input int rd, input int rs, input int imm);
        return {3'(op), 2'(rd), 2'(rs), 1'b0, 4'(imm)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic read_regs(output logic [15:0] rv);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            rv[i*4 +: 4] = dbg_data;
        end
    endtask

    // Instruction-level reference: interprets imem directly.
    logic [3:0] m_r [4];
    logic [3:0] m_pc;
    logic       m_halt;
    int         m_n;

    task automatic model_run(input int maxn);
        logic [11:0] ins;
        logic [3:0]  a, b, imm;
        int          op, rd, rs;
        for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
        m_pc = 4'd0;
        m_halt = 1'b0;
        m_n = 0;
        while (!m_halt && m_n < maxn) begin
            ins = imem[m_pc];
            op  = int'(ins[11:9]);
            rd  = int'(ins[8:7]);
            rs  = int'(ins[6:5]);
            imm = ins[3:0];
            a   = m_r[rd];
            b   = m_r[rs];
            case (op)
                0: m_r[rd] = 4'((int'(a) + int'(b)) % 16);
                1: m_r[rd] = 4'((int'(a) - int'(b) + 16) % 16);
                2: m_r[rd] = a & b;
                3: m_r[rd] = a | b;
                4: m_r[rd] = 4'(15 - int'(a));
                5: m_r[rd] = imm;
                default: ;
            endcase
            if (op == 7) m_halt = 1'b1;
            else if (op == 6 && a != 0) m_pc = imm;
            else m_pc = 4'((int'(m_pc) + 1) % 16);
            m_n++;
        end
    endtask

    typedef struct packed {
        logic [191:0] prog;
        logic [15:0]  regs;
        logic [3:0]   pc;
        logic [7:0]   ndone;
        logic [7:0]   cycles;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [15:0] rv;
        int base;

        vecs[0] = '{prog: 192'({enc(7,0,0,0), enc(0,0,1,0), enc(5,1,0,3), enc(5,0,0,5)}),
                    regs: {4'd0, 4'd0, 4'd3, 4'd8}, pc: 4'd3, ndone: 8'd4, cycles: 8'd12};
        vecs[1] = '{prog: 192'({enc(7,0,0,0), enc(4,1,0,0), enc(1,1,0,0), enc(0,0,1,0),
                                enc(5,1,0,9), enc(5,0,0,7)}),
                    regs: {4'd0, 4'd0, 4'd6, 4'd0}, pc: 4'd5, ndone: 8'd6, cycles: 8'd18};
        vecs[2] = '{prog: 192'({enc(7,0,0,0), enc(6,0,0,2), enc(1,0,1,0), enc(5,1,0,1), enc(5,0,0,3)}),
                    regs: {4'd0, 4'd0, 4'd1, 4'd0}, pc: 4'd4, ndone: 8'd9, cycles: 8'd27};
        vecs[3] = '{prog: 192'({enc(7,0,0,0), enc(6,1,0,0), enc(0,3,3,0), enc(3,3,3,0),
                                enc(2,2,3,0) | 12'h010, enc(5,3,0,10), enc(5,2,0,12) | 12'h010}),
                    regs: {4'd4, 4'd8, 4'd0, 4'd0}, pc: 4'd6, ndone: 8'd7, cycles: 8'd21};

        for (int i = 0; i < 16; i++) imem[i] = 12'd0;

        // Reset state
        do_reset();
        check("rst_pc", 32'(pc), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_instr_done", 32'(instr_done), 0);
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 0);
        read_regs(rv);
        check("rst_regs", 32'(rv), 0);

        // Table vectors
        for (int k = 0; k < 4; k++) begin
            do_reset();
            for (int i = 0; i < 16; i++) imem[i] = vecs[k].prog[i*12 +: 12];
            base = done_cnt;
            pulse_start();
            repeat (int'(vecs[k].cycles) - 1) @(negedge clk);
            check($sformatf("v%0d_not_yet_halted", k), 32'(halted), 0);
            @(negedge clk);
            check($sformatf("v%0d_halted", k), 32'(halted), 1);
            check($sformatf("v%0d_pc", k), 32'(pc), 32'(vecs[k].pc));
            check($sformatf("v%0d_ndone", k), 32'(done_cnt - base), 32'(vecs[k].ndone));
            read_regs(rv);
            check($sformatf("v%0d_regs", k), 32'(rv), 32'(vecs[k].regs));
        end

        // start during DECODE is ignored; start in HALT restarts with regs kept
        do_reset();
        for (int i = 0; i < 16; i++) imem[i] = vecs[0].prog[i*12 +: 12];
        base = done_cnt;
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("decode_start_pc", 32'(pc), 0);
        check("decode_start_exec", 32'(instr_done), 1);
        repeat (10) @(negedge clk);
        check("decode_start_halted", 32'(halted), 1);
        check("decode_start_pc_end", 32'(pc), 3);
        check("decode_start_ndone", 32'(done_cnt - base), 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_pc", 32'(pc), 0);
        check("restart_halted", 32'(halted), 0);
        read_regs(rv);
        check("restart_regs_kept", 32'(rv), 32'({4'd0, 4'd0, 4'd3, 4'd8}));
        repeat (12) @(negedge clk);
        check("restart_halted_again", 32'(halted), 1);
        check("restart_ndone", 32'(done_cnt - base), 8);

        // Reset during EXECUTE of ADD R2,R3
        do_reset();
        for (int i = 0; i < 16; i++) imem[i] = 12'd0;
        imem[0] = enc(5,2,0,4);
        imem[1] = enc(5,3,0,5);
        imem[2] = enc(0,2,3,0);
        imem[3] = enc(7,0,0,0);
        pulse_start();
        repeat (8) @(negedge clk);
        check("midrst_exec", 32'(instr_done), 1);
        check("midrst_operands", 32'({alu_a, alu_b, alu_sel}), 32'({4'd4, 4'd5, 3'd0}));
        dbg_sel = 2'd2;
        #1;
        check("midrst_r2_before_write", 32'(dbg_data), 4);
        rst = 1'b1;
        #1;
        check("midrst_r2_cleared", 32'(dbg_data), 0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_done", 32'(instr_done), 0);
        @(negedge clk);
        rst = 1'b0;
        base = done_cnt;
        repeat (6) @(negedge clk);
        check("midrst_idle_ndone", 32'(done_cnt - base), 0);
        check("midrst_idle_r2", 32'(dbg_data), 0);
        pulse_start();
        repeat (12) @(negedge clk);
        check("midrst_rerun_halted", 32'(halted), 1);
        read_regs(rv);
        check("midrst_rerun_regs", 32'(rv), 32'({4'd5, 4'd9, 4'd0, 4'd0}));

        // PC wrap after 16 non-halting instructions
        do_reset();
        for (int i = 0; i < 16; i++) imem[i] = enc(5, i % 4, 0, i);
        base = done_cnt;
        pulse_start();
        repeat (48) @(negedge clk);
        check("wrap_pc", 32'(pc), 0);
        check("wrap_halted", 32'(halted), 0);
        check("wrap_ndone", 32'(done_cnt - base), 16);
        read_regs(rv);
        check("wrap_regs", 32'(rv), 32'({4'd15, 4'd14, 4'd13, 4'd12}));
        imem[0] = enc(5,3,0,9);
        repeat (3) @(negedge clk);
        check("wrap_refetch_pc", 32'(pc), 1);
        read_regs(rv);
        check("wrap_refetch_r3", 32'(rv[15:12]), 9);

        // Random programs against the instruction-level model
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) imem[i] = 12'($urandom);
            model_run(30);
            do_reset();
            base = done_cnt;
            pulse_start();
            repeat (3 * m_n) @(negedge clk);
            read_regs(rv);
            check($sformatf("rnd%0d_regs", t), 32'(rv), 32'({m_r[3], m_r[2], m_r[1], m_r[0]}));
            check($sformatf("rnd%0d_pc", t), 32'(pc), 32'(m_pc));
            check($sformatf("rnd%0d_halted", t), 32'(halted), 32'(m_halt));
            check($sformatf("rnd%0d_ndone", t), 32'(done_cnt - base), 32'(m_n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
